// File: rtl/typing_timer_pkg.sv
// Shared types and limits for the typing-test countdown timer.
package typing_timer_pkg;

  localparam int unsigned MAX_SECONDS = 599;
  localparam int unsigned BCD_W       = 4;
  localparam int unsigned ELAPSED_W   = 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_RUNNING,
    S_PAUSED,
    S_DONE
  } timer_state_t;

endpackage

// File: rtl/bcd_mmss_down.sv
// M:SS BCD down-counter: loads binary seconds and decrements one second per dec.
module bcd_mmss_down
  import typing_timer_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [ELAPSED_W-1:0] load_val,
  input  logic                 dec,
  output logic [BCD_W-1:0]     min_bcd,
  output logic [BCD_W-1:0]     sec_tens,
  output logic [BCD_W-1:0]     sec_ones,
  output logic                 zero
);

  logic [5:0]       load_rem;
  logic [BCD_W-1:0] load_min;
  logic [BCD_W-1:0] load_tens;
  logic [BCD_W-1:0] load_ones;

  always_comb begin
    load_min  = BCD_W'(load_val / ELAPSED_W'(60));
    load_rem  = 6'(load_val % ELAPSED_W'(60));
    load_tens = BCD_W'(load_rem / 6'd10);
    load_ones = BCD_W'(load_rem % 6'd10);
  end

  assign zero = (min_bcd == '0) && (sec_tens == '0) && (sec_ones == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min_bcd  <= '0;
      sec_tens <= '0;
      sec_ones <= '0;
    end else if (load) begin
      min_bcd  <= load_min;
      sec_tens <= load_tens;
      sec_ones <= load_ones;
    end else if (dec && !zero) begin
      // Borrow ripples ones -> tens -> minutes; minutes never wrap since 0:00 is held.
      if (sec_ones != '0) begin
        sec_ones <= sec_ones - BCD_W'(1);
      end else begin
        sec_ones <= BCD_W'(9);
        if (sec_tens != '0) begin
          sec_tens <= sec_tens - BCD_W'(1);
        end else begin
          sec_tens <= BCD_W'(5);
          min_bcd  <= min_bcd - BCD_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/typing_test_timer.sv
// Typing-test countdown: lifecycle FSM, input priority and elapsed-seconds counter.
module typing_test_timer
  import typing_timer_pkg::*;
#(
  parameter int unsigned DURATION_SEC = 60
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sec_tick,
  input  logic                 arm,
  input  logic                 key_stb,
  input  logic                 pause_tgl,
  input  logic                 abort,
  output logic [BCD_W-1:0]     min_bcd,
  output logic [BCD_W-1:0]     sec_tens,
  output logic [BCD_W-1:0]     sec_ones,
  output logic [ELAPSED_W-1:0] elapsed,
  output logic                 running,
  output logic                 done,
  output logic                 done_pulse
);

  localparam int unsigned DUR_CLAMP = (DURATION_SEC > MAX_SECONDS) ? MAX_SECONDS : DURATION_SEC;
  localparam logic [ELAPSED_W-1:0] DUR_LOAD = ELAPSED_W'(DUR_CLAMP);

  timer_state_t         state;
  timer_state_t         nxt;
  logic                 ld;
  logic [ELAPSED_W-1:0] ld_val;
  logic                 dec;
  logic                 el_clr;
  logic                 zero;
  logic                 last_sec;

  bcd_mmss_down u_count (
    .clk      (clk),
    .rst      (rst),
    .load     (ld),
    .load_val (ld_val),
    .dec      (dec),
    .min_bcd  (min_bcd),
    .sec_tens (sec_tens),
    .sec_ones (sec_ones),
    .zero     (zero)
  );

  assign last_sec = (min_bcd == '0) && (sec_tens == '0) && (sec_ones == BCD_W'(1));

  always_comb begin
    nxt    = state;
    ld     = 1'b0;
    ld_val = '0;
    dec    = 1'b0;
    el_clr = 1'b0;
    if (abort) begin
      nxt    = S_IDLE;
      ld     = 1'b1;
      el_clr = 1'b1;
    end else if (arm) begin
      ld     = 1'b1;
      ld_val = DUR_LOAD;
      el_clr = 1'b1;
      nxt    = (DUR_LOAD == '0) ? S_DONE : S_ARMED;
    end else begin
      unique case (state)
        S_ARMED:   if (key_stb) nxt = S_RUNNING;
        S_RUNNING: begin
          // pause_tgl outranks sec_tick, so a tick in the pausing cycle is dropped.
          if (pause_tgl) begin
            nxt = S_PAUSED;
          end else if (sec_tick && !zero) begin
            dec = 1'b1;
            if (last_sec) nxt = S_DONE;
          end
        end
        S_PAUSED:  if (pause_tgl) nxt = S_RUNNING;
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      elapsed    <= '0;
      running    <= 1'b0;
      done       <= 1'b0;
      done_pulse <= 1'b0;
    end else begin
      state      <= nxt;
      running    <= (nxt == S_RUNNING);
      done       <= (nxt == S_DONE);
      done_pulse <= (nxt == S_DONE) && (state != S_DONE);
      if (el_clr)   elapsed <= '0;
      else if (dec) elapsed <= elapsed + ELAPSED_W'(1);
    end
  end

endmodule

// File: tb/tb_typing_test_timer.sv
// Bench for typing_test_timer: four durations side by side against a seconds-level model.
module tb_typing_test_timer;

  localparam int N = 4;
  localparam int DURS [N] = '{60, 100, 0, 700};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sec_tick = 1'b0, arm = 1'b0, key_stb = 1'b0, pause_tgl = 1'b0, abort = 1'b0;

  logic [3:0] mn [N];
  logic [3:0] tn [N];
  logic [3:0] on [N];
  logic [9:0] el [N];
  logic       rn [N];
  logic       dn [N];
  logic       dp [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    typing_test_timer #(.DURATION_SEC(DURS[g])) dut (
      .clk        (clk),
      .rst        (rst),
      .sec_tick   (sec_tick),
      .arm        (arm),
      .key_stb    (key_stb),
      .pause_tgl  (pause_tgl),
      .abort      (abort),
      .min_bcd    (mn[g]),
      .sec_tens   (tn[g]),
      .sec_ones   (on[g]),
      .elapsed    (el[g]),
      .running    (rn[g]),
      .done       (dn[g]),
      .done_pulse (dp[g])
    );
  end

  // Model: mode 0 idle, 1 armed, 2 running, 3 paused, 4 done; time kept as plain seconds.
  int ms [N];
  int rem [N];
  int elp [N];
  bit mdp [N];

  int checks = 0;
  int errors = 0;

  task automatic model_reset();
    for (int g = 0; g < N; g++) begin
      ms[g] = 0; rem[g] = 0; elp[g] = 0; mdp[g] = 1'b0;
    end
  endtask

  task automatic model_step(input bit ab, input bit ar, input bit k, input bit p, input bit t);
    for (int g = 0; g < N; g++) begin
      bit was_done;
      was_done = (ms[g] == 4);
      if (ab) begin
        ms[g] = 0; rem[g] = 0; elp[g] = 0;
      end else if (ar) begin
        rem[g] = (DURS[g] > 599) ? 599 : DURS[g];
        elp[g] = 0;
        ms[g]  = (rem[g] == 0) ? 4 : 1;
      end else if (ms[g] == 1) begin
        if (k) ms[g] = 2;
      end else if (ms[g] == 2) begin
        if (p) ms[g] = 3;
        else if (t && rem[g] > 0) begin
          rem[g]--; elp[g]++;
          if (rem[g] == 0) ms[g] = 4;
        end
      end else if (ms[g] == 3) begin
        if (p) ms[g] = 2;
      end
      mdp[g] = (ms[g] == 4) && !was_done;
    end
  endtask

  function automatic logic [24:0] act(input int g);
    return {mn[g], tn[g], on[g], el[g], rn[g], dn[g], dp[g]};
  endfunction

  function automatic logic [24:0] expv(input int g);
    int r;
    r = rem[g];
    return {4'(r / 60), 4'((r % 60) / 10), 4'(r % 10), 10'(elp[g]), ms[g] == 2, ms[g] == 4, mdp[g]};
  endfunction

  task automatic chk(input string name, input logic [24:0] a, input logic [24:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got m%0d:%0d%0d el=%0d run=%0b done=%0b dp=%0b, want m%0d:%0d%0d el=%0d run=%0b done=%0b dp=%0b",
               name, a[24:21], a[20:17], a[16:13], a[12:3], a[2], a[1], a[0],
               e[24:21], e[20:17], e[16:13], e[12:3], e[2], e[1], e[0]);
    end
  endtask

  task automatic chk_bits(input string name, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, a, e);
    end
  endtask

  // Drive one cycle of inputs, advance the model with the edge, compare every instance.
  task automatic cyc(input bit ab, input bit ar, input bit k, input bit p, input bit t, input string tag);
    abort = ab; arm = ar; key_stb = k; pause_tgl = p; sec_tick = t;
    @(posedge clk);
    model_step(ab, ar, k, p, t);
    #1;
    abort = 1'b0; arm = 1'b0; key_stb = 1'b0; pause_tgl = 1'b0; sec_tick = 1'b0;
    for (int g = 0; g < N; g++) chk($sformatf("%s/d%0d", tag, DURS[g]), act(g), expv(g));
  endtask

  function automatic int digits(input int g);
    return mn[g] * 100 + tn[g] * 10 + on[g];
  endfunction

  typedef struct {
    bit ab, ar, k, p, t;
    int m, st, so, e;
    bit r, d, dpl;
  } vec_t;

  vec_t tbl [14];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int pulses;
    model_reset();
    #3;
    for (int g = 0; g < N; g++) chk($sformatf("reset/d%0d", DURS[g]), act(g), 25'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Instance 0 (60 s) table: abort arm key pause tick | m st so el run done dp
    tbl[0]  = '{0,1,0,0,0, 1,0,0,0, 0,0,0};
    tbl[1]  = '{0,0,1,0,1, 1,0,0,0, 1,0,0};
    tbl[2]  = '{0,0,0,0,1, 0,5,9,1, 1,0,0};
    tbl[3]  = '{0,0,0,1,1, 0,5,9,1, 0,0,0};
    tbl[4]  = '{0,0,0,0,1, 0,5,9,1, 0,0,0};
    tbl[5]  = '{0,0,0,1,0, 0,5,9,1, 1,0,0};
    tbl[6]  = '{0,0,0,0,1, 0,5,8,2, 1,0,0};
    tbl[7]  = '{0,0,1,0,0, 0,5,8,2, 1,0,0};
    tbl[8]  = '{0,1,0,0,0, 1,0,0,0, 0,0,0};
    tbl[9]  = '{0,0,0,0,1, 1,0,0,0, 0,0,0};
    tbl[10] = '{0,0,1,0,0, 1,0,0,0, 1,0,0};
    tbl[11] = '{1,1,0,0,0, 0,0,0,0, 0,0,0};
    tbl[12] = '{0,0,0,1,0, 0,0,0,0, 0,0,0};
    tbl[13] = '{0,0,0,0,1, 0,0,0,0, 0,0,0};
    for (int i = 0; i < 14; i++) begin
      cyc(tbl[i].ab, tbl[i].ar, tbl[i].k, tbl[i].p, tbl[i].t, $sformatf("tblm%0d", i));
      chk($sformatf("tbl%0d", i), act(0),
          {4'(tbl[i].m), 4'(tbl[i].st), 4'(tbl[i].so), 10'(tbl[i].e), tbl[i].r, tbl[i].d, tbl[i].dpl});
    end

    // Full 60-second run, borrow chain on 100 s, zero and clamped durations.
    cyc(0,1,0,0,0, "run_arm");
    chk_bits("zero_dur_done", {dn[2], dp[2]}, 3);
    chk_bits("clamp_959", digits(3), 959);
    cyc(0,0,0,0,0, "run_idle");
    chk_bits("zero_dur_pulse_once", dp[2], 0);
    cyc(0,0,1,0,0, "run_key");
    pulses = 0;
    for (int i = 1; i <= 61; i++) begin
      cyc(0,0,0,0,1, $sformatf("run_t%0d", i));
      pulses += dp[0];
      if (i == 1)  chk_bits("borrow_139", digits(1), 139);
      if (i == 40) chk_bits("borrow_100", digits(1), 100);
      if (i == 41) chk_bits("borrow_059", digits(1), 59);
      if (i == 59) chk_bits("d60_001", digits(0), 1);
      if (i == 60) chk_bits("d60_done_pulse", {dn[0], dp[0], rn[0]}, 6);
    end
    chk_bits("d60_pulse_count", pulses, 1);
    chk_bits("d60_elapsed", el[0], 60);
    chk_bits("d60_hold_000", digits(0), 0);

    // Pause freezes the display at 0:55.
    cyc(0,1,0,0,0, "pz_arm");
    cyc(0,0,1,0,0, "pz_key");
    for (int i = 0; i < 5; i++) cyc(0,0,0,0,1, "pz_tick");
    cyc(0,0,0,1,0, "pz_pause");
    for (int i = 0; i < 10; i++) cyc(0,0,0,0,1, "pz_held");
    chk_bits("pause_055", digits(0), 55);
    chk_bits("pause_not_running", rn[0], 0);
    cyc(0,0,0,1,0, "pz_resume");
    cyc(0,0,0,0,1, "pz_tick2");
    chk_bits("resume_054", digits(0), 54);

    // Asynchronous reset in the middle of a run at 0:42.
    cyc(0,1,0,0,0, "rs_arm");
    cyc(0,0,1,0,0, "rs_key");
    for (int i = 0; i < 18; i++) cyc(0,0,0,0,1, "rs_tick");
    chk_bits("rs_at_042", digits(0), 42);
    #2;
    rst = 1'b1;
    #1;
    for (int g = 0; g < N; g++) chk($sformatf("rs_async/d%0d", DURS[g]), act(g), 25'd0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) cyc(0,0,0,i[0],1, "rs_after");
    chk_bits("rs_stays_idle", {rn[0], dn[0], 4'(digits(0))}, 0);

    // Randomised traffic against the model.
    for (int i = 0; i < 500; i++) begin
      cyc($urandom_range(0, 39) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 0, $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
